// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: memory FSM state
// encoding, forwarding select codes, control-field bit positions and a
// register-match helper used by both forwarding and load-use detection.
package pipe_hazard_ctrl_pkg;

  typedef logic [2:0] reg_addr_t;

  // Memory sequencing FSM states
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  // EX operand source selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Bit positions inside the pipeline control fields
  localparam int WB_REGWRITE = 1;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;

  // A producer matches a consumer only for a real (non-zero) register.
  function automatic logic addr_hit(input reg_addr_t dst, input reg_addr_t src);
    return (dst != 3'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational EX-stage forwarding compare for both ALU operands.
// The EX/MEM producer is younger than MEM/WB, so it wins when both match.
module fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic      exmem_reg_write,
  input  reg_addr_t exmem_dst,
  input  logic      memwb_reg_write,
  input  reg_addr_t memwb_dst,
  input  reg_addr_t src_a,
  input  reg_addr_t src_b,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  function automatic logic [1:0] pick(input reg_addr_t src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (exmem_reg_write && addr_hit(exmem_dst, src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && addr_hit(memwb_dst, src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  // Independent select per operand, same priority rule
  always_comb begin
    fwd_a = pick(src_a);
    fwd_b = pick(src_b);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding,
// load-use stall, branch flush and a pipeline-wide freeze around a
// variable-latency data memory access with a timeout into a sticky error.
//
// Data memory handshake: dmem_req is a level held high from the cycle after
// the access is seen in MEM until the cycle after dmem_ack; dmem_ack is a
// single-cycle completion pulse and only counts while the request is up
// (MEM_WAIT). An ack in any other state is ignored.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic [2:0]       idex_rs,
  input  logic [2:0]       idex_rt,
  input  logic [2:0]       idex_dst,
  input  logic             idex_mem_read,
  input  logic [2:0]       exmem_dst,
  input  logic [1:0]       exmem_wb,
  input  logic [1:0]       exmem_mem,
  input  logic [2:0]       memwb_dst,
  input  logic             memwb_reg_write,
  input  logic             branch_taken,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             dmem_req,
  output logic             ctrl_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]       state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             access_done;
  logic             run_q;
  logic             mem_access;
  logic             req_cond;
  logic             lu;
  logic [1:0]       fwd_a_raw;
  logic [1:0]       fwd_b_raw;
  logic             unused_wb0;

  assign unused_wb0 = exmem_wb[0];
  assign dbg_state  = state;

  fwd_unit u_fwd (
    .exmem_reg_write (exmem_wb[WB_REGWRITE]),
    .exmem_dst       (exmem_dst),
    .memwb_reg_write (memwb_reg_write),
    .memwb_dst       (memwb_dst),
    .src_a           (idex_rs),
    .src_b           (idex_rt),
    .fwd_a           (fwd_a_raw),
    .fwd_b           (fwd_b_raw)
  );

  assign mem_access = exmem_mem[MEM_READ] | exmem_mem[MEM_WRITE];
  // An access already completed in this MEM slot must not be re-issued.
  assign req_cond   = run_q && (state == ST_RUN) && mem_access && !access_done;
  assign lu         = idex_mem_read &&
                      (addr_hit(idex_dst, id_rs) || addr_hit(idex_dst, id_rt));

  // Stage enables: freeze > branch > load-use > normal advance
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    if (run_q) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      if ((state != ST_RUN) || req_cond) begin
        // Freeze starts in the same cycle the access is detected.
        pipe_freeze = 1'b1;
      end else if (branch_taken) begin
        // ID holds a wrong-path instruction, so any load-use there is moot.
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu) begin
        idex_bubble = 1'b1;
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
      end
    end
  end

  // Memory sequencing FSM, request level, timeout and sticky error
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      dmem_req    <= 1'b0;
      ctrl_error  <= 1'b0;
      access_done <= 1'b0;
      run_q       <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      run_q <= 1'b1;
      case (state)
        ST_RUN: begin
          if (!pipe_freeze) begin
            access_done <= 1'b0;
          end
          if (req_cond) begin
            state    <= ST_MEM_WAIT;
            dmem_req <= 1'b1;
            tmo_cnt  <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ack) begin
            state       <= ST_RUN;
            dmem_req    <= 1'b0;
            access_done <= 1'b1;
          end else if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
            state      <= ST_ERROR;
            dmem_req   <= 1'b0;
            ctrl_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_ERROR: begin
          dmem_req   <= 1'b0;
          ctrl_error <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles the PC is held, excluding the dead ERROR state
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (run_q && !pc_we && (state != ST_ERROR) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share all inputs except
// exmem_mem: the main one uses the default timeout, the second a timeout of 3
// so the ERROR path can be reached quickly without disturbing the main one.
module tb_pipe_hazard_ctrl;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_ERR = 2'd2;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_n;
  always #5 clk_i = ~clk_i;

  logic [2:0] id_rs, id_rt, idex_rs, idex_rt, idex_dst, exmem_dst, memwb_dst;
  logic       idex_mem_read, memwb_reg_write, branch_taken, dmem_ack;
  logic [1:0] exmem_wb, exmem_mem, to_exmem_mem;

  logic        pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze, dmem_req, ctrl_error;
  logic [1:0]  fwd_a, fwd_b, dbg_state;
  logic [15:0] stall_cnt;

  logic        t_pc_we, t_ifid_we, t_ifid_flush, t_idex_bubble, t_pipe_freeze, t_dmem_req, t_ctrl_error;
  logic [1:0]  t_fwd_a, t_fwd_b, t_dbg_state;
  logic [15:0] t_stall_cnt;

  pipe_hazard_ctrl dut (
    .clk_i(clk_i), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_dst(idex_dst),
    .idex_mem_read(idex_mem_read), .exmem_dst(exmem_dst), .exmem_wb(exmem_wb),
    .exmem_mem(exmem_mem), .memwb_dst(memwb_dst), .memwb_reg_write(memwb_reg_write),
    .branch_taken(branch_taken), .dmem_ack(dmem_ack), .pc_we(pc_we),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_freeze(pipe_freeze), .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_req(dmem_req),
    .ctrl_error(ctrl_error), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(3)) dut_to (
    .clk_i(clk_i), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_dst(idex_dst),
    .idex_mem_read(idex_mem_read), .exmem_dst(exmem_dst), .exmem_wb(exmem_wb),
    .exmem_mem(to_exmem_mem), .memwb_dst(memwb_dst), .memwb_reg_write(memwb_reg_write),
    .branch_taken(branch_taken), .dmem_ack(dmem_ack), .pc_we(t_pc_we),
    .ifid_we(t_ifid_we), .ifid_flush(t_ifid_flush), .idex_bubble(t_idex_bubble),
    .pipe_freeze(t_pipe_freeze), .fwd_a(t_fwd_a), .fwd_b(t_fwd_b), .dmem_req(t_dmem_req),
    .ctrl_error(t_ctrl_error), .stall_cnt(t_stall_cnt), .dbg_state(t_dbg_state)
  );

  logic [12:0] obs_main, obs_to;
  assign obs_main = {dbg_state, pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze,
                     dmem_req, ctrl_error, fwd_a, fwd_b};
  assign obs_to   = {t_dbg_state, t_pc_we, t_ifid_we, t_ifid_flush, t_idex_bubble, t_pipe_freeze,
                     t_dmem_req, t_ctrl_error, t_fwd_a, t_fwd_b};

  // scoreboard: bit 13 selects the instance, bits 12:0 the expected vector
  logic [13:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [12:0] ev(input logic [1:0] st, input logic pc, input logic ifw,
                                     input logic fl, input logic bub, input logic frz,
                                     input logic req, input logic err,
                                     input logic [1:0] fa, input logic [1:0] fb);
    return {st, pc, ifw, fl, bub, frz, req, err, fa, fb};
  endfunction

  // driver tasks
  task automatic expect_out(input string tag, input logic [12:0] e, input logic sel);
    exp_q.push_back({sel, e});
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; idex_rs = 0; idex_rt = 0; idex_dst = 0; exmem_dst = 0;
    memwb_dst = 0; idex_mem_read = 0; memwb_reg_write = 0; branch_taken = 0;
    dmem_ack = 0; exmem_wb = 0; exmem_mem = 0; to_exmem_mem = 0;
  endtask

  // monitor: compare every expectation pushed for this cycle, mid-cycle
  initial begin
    logic [13:0] e;
    string       t;
    forever begin
      @(negedge clk_i);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, e[13] ? 32'(obs_to) : 32'(obs_main), 32'(e[12:0]));
      end
    end
  end

  logic [12:0] idle, zero, mw, to_err;

  initial begin
    idle   = ev(S_RUN, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    zero   = ev(S_RUN, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    mw     = ev(S_MW,  0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00);
    to_err = ev(S_ERR, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
    clear_inputs();
    rst_n = 1'b0;
    tick();
    // reset state, run gating
    expect_out("rst_state", zero, 0);
    check_eq("rst_stall", 32'(stall_cnt), 0);
    tick();
    rst_n = 1'b1;
    expect_out("run_gate", zero, 0);
    tick();
    expect_out("idle", idle, 0);
    tick();
    // forwarding
    exmem_wb = 2'b10; exmem_dst = 3; idex_rs = 3; memwb_reg_write = 1; memwb_dst = 3; idex_rt = 3;
    expect_out("fwd_exmem", ev(S_RUN, 1, 1, 0, 0, 0, 0, 0, 2'b10, 2'b10), 0);
    tick();
    exmem_dst = 0;
    expect_out("fwd_memwb", ev(S_RUN, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b01), 0);
    tick();
    exmem_wb = 2'b01; exmem_dst = 3; memwb_dst = 5; idex_rs = 3; idex_rt = 5;
    expect_out("fwd_nowrite", ev(S_RUN, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01), 0);
    tick();
    exmem_wb = 2'b10; exmem_dst = 0; memwb_dst = 0; idex_rs = 0; idex_rt = 0;
    expect_out("fwd_r0", idle, 0);
    tick();
    // load-use
    clear_inputs();
    idex_mem_read = 1; idex_dst = 2; id_rt = 2;
    expect_out("lu", ev(S_RUN, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00), 0);
    check_eq("lu_stall_before", 32'(stall_cnt), 0);
    tick();
    clear_inputs();
    expect_out("lu_release", idle, 0);
    check_eq("lu_stall_after", 32'(stall_cnt), 1);
    tick();
    idex_mem_read = 1; idex_dst = 0;
    expect_out("lu_r0", idle, 0);
    tick();
    // branch beats load-use
    idex_dst = 2; id_rt = 2; branch_taken = 1;
    expect_out("br_over_lu", ev(S_RUN, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00), 0);
    tick();
    clear_inputs();
    check_eq("br_stall", 32'(stall_cnt), 1);
    // memory wait with ack on the 4th wait cycle, branch raised under freeze
    exmem_mem = 2'b10;
    expect_out("mw_req", ev(S_RUN, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00), 0);
    tick();
    expect_out("mw_w1", mw, 0);
    tick();
    branch_taken = 1;
    expect_out("mw_w2_br", mw, 0);
    tick();
    expect_out("mw_w3_br", mw, 0);
    tick();
    dmem_ack = 1;
    expect_out("mw_w4_ack", mw, 0);
    tick();
    dmem_ack = 0;
    expect_out("mw_release_br", ev(S_RUN, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00), 0);
    check_eq("mw_stall", 32'(stall_cnt), 6);
    tick();
    clear_inputs();
    expect_out("mw_after", idle, 0);
    check_eq("mw_stall_hold", 32'(stall_cnt), 6);
    check_eq("to_stall_start", 32'(t_stall_cnt), 1);
    tick();
    // timeout on the short-timeout instance
    to_exmem_mem = 2'b10;
    expect_out("to_req", ev(S_RUN, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00), 1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      expect_out($sformatf("to_w%0d", i), mw, 1);
      tick();
    end
    to_exmem_mem = 2'b00;
    expect_out("to_error", to_err, 1);
    tick();
    dmem_ack = 1;
    expect_out("to_sticky_ack", to_err, 1);
    expect_out("ack_run_cycle", idle, 0);
    tick();
    dmem_ack = 0;
    expect_out("to_sticky", to_err, 1);
    expect_out("ack_run_ignored", idle, 0);
    check_eq("to_stall_err", 32'(t_stall_cnt), 5);
    tick();
    check_eq("to_stall_frozen", 32'(t_stall_cnt), 5);
    // one-cycle reset clears ERROR
    rst_n = 1'b0;
    expect_out("to_rst_cycle", to_err, 1);
    tick();
    rst_n = 1'b1;
    expect_out("to_post_rst", zero, 1);
    expect_out("main_post_rst", zero, 0);
    check_eq("to_rst_stall", 32'(t_stall_cnt), 0);
    check_eq("rst_stall2", 32'(stall_cnt), 0);
    tick();
    expect_out("to_run_again", idle, 1);
    tick();
    // reset in the middle of a wait
    exmem_mem = 2'b01;
    expect_out("rw_req", ev(S_RUN, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00), 0);
    tick();
    expect_out("rw_w1", mw, 0);
    tick();
    rst_n = 1'b0;
    expect_out("rw_rst_cycle", mw, 0);
    tick();
    rst_n = 1'b1;
    exmem_mem = 2'b00;
    expect_out("rw_req_dropped", zero, 0);
    tick();
    #3;
    check_eq("sb_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
